i2s_capture_scheduler: RTL and testbench

//  Sequences I2S audio capture for the visualizer: generates sck/ws for the I2S receiver from the
//  22.579 MHz audio clock, and arms/stops capture on a clean left-channel boundary. Selects

---
 rtl/i2s_pkg.sv | 29 ++
 rtl/i2s_clk_gen.sv | 64 ++++++
 rtl/i2s_capture_scheduler.sv | 200 ++++++++++++++++++++
 tb/tb_i2s_capture_scheduler.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S capture scheduler: FSM encodings, channel
// indices and default stream widths.
package i2s_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  localparam int CH_L = 0;
  localparam int CH_R = 1;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_WORD_BITS  = 32;

  // Tag 0 is the left channel, tag 1 the right channel.
  function automatic logic chan_enabled(input logic [1:0] mask, input logic tag);
    logic en;
    if (tag) begin
      en = mask[CH_R];
    end else begin
      en = mask[CH_L];
    end
    return en;
  endfunction

endpackage

// File: rtl/i2s_clk_gen.sv
// I2S bit clock and word-select generator. Free-running in every state of the
// scheduler; sck_fall pulses in the cycle where sck has just dropped.
module i2s_clk_gen #(
  parameter int SCK_DIV   = 8,
  parameter int WORD_BITS = 32
) (
  input  logic clk,
  input  logic reset,
  output logic sck,
  output logic ws,
  output logic sck_fall
);

  localparam int DIV_W = $clog2(SCK_DIV);
  localparam int BIT_W = $clog2(2 * WORD_BITS);

  logic [DIV_W-1:0] div_cnt_r;
  logic [DIV_W-1:0] div_next_s;
  logic [BIT_W-1:0] bit_cnt_r;
  logic [BIT_W-1:0] bit_next_s;
  logic             wrap_s;
  logic             sck_r;
  logic             ws_r;
  logic             sck_fall_r;

  // Next divider and bit-position values.
  always_comb begin
    wrap_s     = (div_cnt_r == DIV_W'(SCK_DIV - 1));
    div_next_s = div_cnt_r;
    bit_next_s = bit_cnt_r;
    if (wrap_s) begin
      div_next_s = '0;
      if (bit_cnt_r == BIT_W'(2 * WORD_BITS - 1)) begin
        bit_next_s = '0;
      end else begin
        bit_next_s = bit_cnt_r + BIT_W'(1);
      end
    end else begin
      div_next_s = div_cnt_r + DIV_W'(1);
    end
  end

  // sck/ws are registered from the next counter values so they track the counters exactly.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_r  <= '0;
      bit_cnt_r  <= '0;
      sck_r      <= 1'b0;
      ws_r       <= 1'b0;
      sck_fall_r <= 1'b0;
    end else begin
      div_cnt_r  <= div_next_s;
      bit_cnt_r  <= bit_next_s;
      sck_r      <= (div_next_s >= DIV_W'(SCK_DIV / 2));
      ws_r       <= (bit_next_s >= BIT_W'(WORD_BITS));
      sck_fall_r <= wrap_s;
    end
  end

  assign sck      = sck_r;
  assign ws       = ws_r;
  assign sck_fall = sck_fall_r;

endmodule

// File: rtl/i2s_capture_scheduler.sv
// Arms/stops I2S capture on a left-channel boundary, selects channels and
// packetises receiver beats into FRAME_LEN-sample AXI-stream frames.
module i2s_capture_scheduler
  import i2s_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int WORD_BITS  = DEFAULT_WORD_BITS,
  parameter int SCK_DIV    = 8,
  parameter int FRAME_LEN  = 256,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cfg_start,
  input  logic                  cfg_stop,
  input  logic [1:0]            cfg_chan_mask,
  output logic                  busy,
  output logic                  overflow,
  output logic [CNT_WIDTH-1:0]  drop_count,
  output logic                  sck,
  output logic                  ws,
  input  logic                  s_tvalid,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  output logic                  s_tready,
  output logic                  m_tvalid,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tlast,
  input  logic                  m_tready
);

  localparam int SCNT_W = $clog2(FRAME_LEN);

  state_t                state_r;
  state_t                state_s;
  logic [1:0]            mask_r;
  logic                  tag_r;
  logic [SCNT_W-1:0]     sample_cnt_r;
  logic                  m_tvalid_r;
  logic [DATA_WIDTH-1:0] m_tdata_r;
  logic                  m_tlast_r;
  logic                  overflow_r;
  logic [CNT_WIDTH-1:0]  drop_count_r;
  logic                  busy_r;
  logic                  ws_prev_r;

  logic ws_s;
  logic sck_s;
  logic sck_fall_s;
  logic ws_fall_s;
  logic start_s;
  logic active_s;
  logic capture_s;
  logic fwd_s;
  logic out_drain_s;
  logic load_s;
  logic drop_s;
  logic last_s;

  i2s_clk_gen #(
    .SCK_DIV   (SCK_DIV),
    .WORD_BITS (WORD_BITS)
  ) u_clk_gen (
    .clk      (clk),
    .reset    (reset),
    .sck      (sck_s),
    .ws       (ws_s),
    .sck_fall (sck_fall_s)
  );

  // Datapath qualifiers. Once a stop is pending, no new frame may begin after the current one.
  always_comb begin
    ws_fall_s   = sck_fall_s & ws_prev_r & ~ws_s;
    start_s     = cfg_start & ~cfg_stop;
    active_s    = (state_r == ST_RUN) || (state_r == ST_DRAIN);
    capture_s   = (state_r == ST_RUN) ||
                  ((state_r == ST_DRAIN) && (sample_cnt_r != SCNT_W'(0)));
    fwd_s       = capture_s & s_tvalid & chan_enabled(mask_r, tag_r);
    out_drain_s = m_tvalid_r & m_tready;
    load_s      = fwd_s & (~m_tvalid_r | m_tready);
    drop_s      = fwd_s & ~load_s;
    last_s      = (sample_cnt_r == SCNT_W'(FRAME_LEN - 1));
  end

  // Capture sequencing FSM next state.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_s) begin
          state_s = ST_ARM;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ARM: begin
        if (cfg_stop) begin
          state_s = ST_IDLE;
        end else if (ws_fall_s) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_ARM;
        end
      end
      ST_RUN: begin
        if (cfg_stop && (mask_r == 2'b00)) begin
          state_s = ST_IDLE;
        end else if (cfg_stop) begin
          state_s = ST_DRAIN;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (out_drain_s && m_tlast_r) begin
          state_s = ST_IDLE;
        end else if (!m_tvalid_r && (sample_cnt_r == SCNT_W'(0))) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // FSM state, arm-time configuration and channel tagging.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      busy_r    <= 1'b0;
      mask_r    <= 2'b00;
      tag_r     <= 1'b0;
      ws_prev_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      busy_r    <= (state_s != ST_IDLE);
      ws_prev_r <= ws_s;
      if ((state_r == ST_IDLE) && start_s) begin
        mask_r <= cfg_chan_mask;
      end
      if (state_r == ST_ARM) begin
        tag_r <= 1'b0;
      end else if (active_s && s_tvalid) begin
        tag_r <= ~tag_r;
      end
    end
  end

  // Single-entry output register, frame position and drop accounting.
  always_ff @(posedge clk) begin
    if (reset) begin
      m_tvalid_r   <= 1'b0;
      m_tdata_r    <= '0;
      m_tlast_r    <= 1'b0;
      sample_cnt_r <= '0;
      overflow_r   <= 1'b0;
      drop_count_r <= '0;
    end else begin
      if (load_s) begin
        m_tvalid_r <= 1'b1;
        m_tdata_r  <= s_tdata;
        m_tlast_r  <= last_s;
      end else if (out_drain_s) begin
        m_tvalid_r <= 1'b0;
        m_tlast_r  <= 1'b0;
      end

      if ((state_r == ST_IDLE) && start_s) begin
        sample_cnt_r <= '0;
      end else if (load_s && last_s) begin
        sample_cnt_r <= '0;
      end else if (load_s) begin
        sample_cnt_r <= sample_cnt_r + SCNT_W'(1);
      end

      if ((state_r == ST_IDLE) && start_s) begin
        overflow_r   <= 1'b0;
        drop_count_r <= '0;
      end else if (drop_s) begin
        overflow_r <= 1'b1;
        if (drop_count_r != {CNT_WIDTH{1'b1}}) begin
          drop_count_r <= drop_count_r + CNT_WIDTH'(1);
        end
      end
    end
  end

  assign busy       = busy_r;
  assign overflow   = overflow_r;
  assign drop_count = drop_count_r;
  assign sck        = sck_s;
  assign ws         = ws_s;
  assign s_tready   = 1'b1;
  assign m_tvalid   = m_tvalid_r;
  assign m_tdata    = m_tdata_r;
  assign m_tlast    = m_tlast_r;

endmodule

// File: tb/tb_i2s_capture_scheduler.sv
// Self-checking bench for i2s_capture_scheduler: a transaction model pushes
// expected output beats to a queue that is popped on every downstream handshake.
module tb_i2s_capture_scheduler;

  localparam int DW = 32;
  localparam int FL = 4;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          cfg_start;
  logic          cfg_stop;
  logic [1:0]    cfg_chan_mask;
  logic          busy;
  logic          overflow;
  logic [CW-1:0] drop_count;
  logic          sck;
  logic          ws;
  logic          s_tvalid;
  logic [DW-1:0] s_tdata;
  logic          s_tready;
  logic          m_tvalid;
  logic [DW-1:0] m_tdata;
  logic          m_tlast;
  logic          m_tready;

  i2s_capture_scheduler #(
    .DATA_WIDTH (DW),
    .WORD_BITS  (32),
    .SCK_DIV    (8),
    .FRAME_LEN  (FL),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .cfg_start     (cfg_start),
    .cfg_stop      (cfg_stop),
    .cfg_chan_mask (cfg_chan_mask),
    .busy          (busy),
    .overflow      (overflow),
    .drop_count    (drop_count),
    .sck           (sck),
    .ws            (ws),
    .s_tvalid      (s_tvalid),
    .s_tdata       (s_tdata),
    .s_tready      (s_tready),
    .m_tvalid      (m_tvalid),
    .m_tdata       (m_tdata),
    .m_tlast       (m_tlast),
    .m_tready      (m_tready)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [DW:0] sb_q[$];

  // Transaction model state
  logic       run_m;
  logic       drain_m;
  logic       tag_m;
  logic [1:0] mask_m;
  int         cnt_m;
  logic       occ_m;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive a beat, settle the handshake for this cycle, advance.
  task automatic step(input logic v, input logic [DW-1:0] d);
    logic [DW:0] e;
    logic        ch;
    logic        loaded;
    loaded   = 1'b0;
    s_tvalid = v;
    s_tdata  = d;
    if (m_tvalid && m_tready) begin
      check_eq("sb_nonempty", 32'(sb_q.size() != 0), 32'(1));
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check_eq("m_tdata", m_tdata, e[DW-1:0]);
        check_eq("m_tlast", 32'(m_tlast), 32'(e[DW]));
      end
    end
    if (v && run_m) begin
      ch    = tag_m;
      tag_m = ~tag_m;
      if (mask_m[ch] && (!drain_m || cnt_m != 0)) begin
        if (occ_m && !m_tready) begin
          // dropped: no output expected
        end else begin
          sb_q.push_back({(cnt_m == FL - 1), d});
          cnt_m  = (cnt_m == FL - 1) ? 0 : cnt_m + 1;
          loaded = 1'b1;
        end
      end
    end
    if (loaded) occ_m = 1'b1;
    else if (occ_m && m_tready) occ_m = 1'b0;
    if (cfg_stop && run_m) begin
      if (mask_m == 2'b00) run_m = 1'b0;
      else drain_m = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic arm(input logic [1:0] mask);
    logic prev;
    logic found;
    found         = 1'b0;
    cfg_chan_mask = mask;
    cfg_start     = 1'b1;
    prev          = ws;
    step(1'b0, '0);
    cfg_start = 1'b0;
    check_eq("arm_busy", 32'(busy), 32'(1));
    check_eq("arm_overflow_clr", 32'(overflow), 32'(0));
    check_eq("arm_drop_clr", 32'(drop_count), 32'(0));
    for (int i = 0; i < 600; i++) begin
      if (prev && !ws) begin
        found = 1'b1;
        break;
      end
      prev = ws;
      step(1'b1, 32'hDEAD_0000 + 32'(i));
    end
    check_eq("arm_ws_fall", 32'(found), 32'(1));
    step(1'b0, '0);
    run_m   = 1'b1;
    drain_m = 1'b0;
    tag_m   = 1'b0;
    mask_m  = mask;
    cnt_m   = 0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 50; i++) begin
      if (!busy) break;
      step(1'b0, '0);
    end
    check_eq("idle_reached", 32'(busy), 32'(0));
    run_m = 1'b0;
  endtask

  initial begin
    reset = 1'b1; cfg_start = 1'b0; cfg_stop = 1'b0; cfg_chan_mask = 2'b00;
    s_tvalid = 1'b0; s_tdata = '0; m_tready = 1'b1;
    run_m = 1'b0; drain_m = 1'b0; tag_m = 1'b0; mask_m = 2'b00; cnt_m = 0; occ_m = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b0, '0);

    // 1: reset values, then sck/ws cadence
    reset = 1'b0;
    check_eq("rst_busy", 32'(busy), 32'(0));
    check_eq("rst_m_tvalid", 32'(m_tvalid), 32'(0));
    check_eq("rst_m_tlast", 32'(m_tlast), 32'(0));
    check_eq("rst_m_tdata", m_tdata, 32'(0));
    check_eq("rst_overflow", 32'(overflow), 32'(0));
    check_eq("rst_drop_count", 32'(drop_count), 32'(0));
    check_eq("rst_sck", 32'(sck), 32'(0));
    check_eq("rst_ws", 32'(ws), 32'(0));
    check_eq("s_tready", 32'(s_tready), 32'(1));
    for (int k = 1; k <= 520; k++) begin
      step(1'b0, '0);
      check_eq("sck_phase", 32'(sck), 32'((k % 8) >= 4));
      check_eq("ws_phase", 32'(ws), 32'(((k / 8) % 64) >= 32));
    end
    check_eq("idle_busy", 32'(busy), 32'(0));

    // start+stop together: stop wins
    cfg_start = 1'b1; cfg_stop = 1'b1; cfg_chan_mask = 2'b11;
    step(1'b0, '0);
    cfg_start = 1'b0; cfg_stop = 1'b0;
    check_eq("start_stop_busy", 32'(busy), 32'(0));

    // 2: stereo, data 1..8, latency 1
    arm(2'b11);
    step(1'b1, 32'd1);
    check_eq("latency_valid", 32'(m_tvalid), 32'(1));
    check_eq("latency_data", m_tdata, 32'd1);
    for (int i = 2; i <= 8; i++) step(1'b1, 32'(i));
    cfg_stop = 1'b1; step(1'b0, '0); cfg_stop = 1'b0;
    wait_idle();
    check_eq("t2_sb_empty", 32'(sb_q.size()), 32'(0));

    // 3: left only
    arm(2'b01);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 32'h100 + 32'(i));
      step(1'b1, 32'h200 + 32'(i));
    end
    cfg_stop = 1'b1; step(1'b0, '0); cfg_stop = 1'b0;
    wait_idle();
    check_eq("t3_sb_empty", 32'(sb_q.size()), 32'(0));

    // 4: downstream stall, two drops
    arm(2'b11);
    m_tready = 1'b0;
    step(1'b1, 32'h41);
    step(1'b1, 32'h42);
    step(1'b1, 32'h43);
    check_eq("t4_drop_count", 32'(drop_count), 32'(2));
    check_eq("t4_overflow", 32'(overflow), 32'(1));
    step(1'b0, '0);
    step(1'b0, '0);
    check_eq("t4_hold_valid", 32'(m_tvalid), 32'(1));
    check_eq("t4_hold_data", m_tdata, 32'h41);
    check_eq("t4_hold_last", 32'(m_tlast), 32'(0));
    m_tready = 1'b1;
    cfg_stop = 1'b1; step(1'b0, '0); cfg_stop = 1'b0;
    step(1'b1, 32'h44);
    step(1'b1, 32'h45);
    step(1'b1, 32'h46);
    wait_idle();
    check_eq("t4_sb_empty", 32'(sb_q.size()), 32'(0));
    check_eq("t4_drop_kept", 32'(drop_count), 32'(2));

    // 5: stop at sample 2 of 4 (arm also checks counters were cleared)
    arm(2'b11);
    step(1'b1, 32'h51);
    step(1'b1, 32'h52);
    cfg_stop = 1'b1; step(1'b0, '0); cfg_stop = 1'b0;
    step(1'b1, 32'h53);
    step(1'b1, 32'h54);
    step(1'b1, 32'h55);
    step(1'b1, 32'h56);
    check_eq("t5_busy", 32'(busy), 32'(0));
    step(1'b1, 32'h57);
    check_eq("t5_no_valid", 32'(m_tvalid), 32'(0));
    check_eq("t5_sb_empty", 32'(sb_q.size()), 32'(0));

    // mask 00: nothing forwarded, stop goes straight to idle
    arm(2'b00);
    for (int i = 0; i < 4; i++) step(1'b1, 32'h70 + 32'(i));
    check_eq("m00_no_valid", 32'(m_tvalid), 32'(0));
    cfg_stop = 1'b1; step(1'b0, '0); cfg_stop = 1'b0;
    check_eq("m00_busy", 32'(busy), 32'(0));

    // 6: reset mid-frame with a held sample and a drop
    arm(2'b11);
    m_tready = 1'b0;
    step(1'b1, 32'h61);
    step(1'b1, 32'h62);
    check_eq("t6_pre_valid", 32'(m_tvalid), 32'(1));
    check_eq("t6_pre_drop", 32'(drop_count), 32'(1));
    reset = 1'b1;
    step(1'b0, '0);
    reset = 1'b0;
    sb_q.delete();
    run_m = 1'b0; occ_m = 1'b0;
    check_eq("t6_valid", 32'(m_tvalid), 32'(0));
    check_eq("t6_busy", 32'(busy), 32'(0));
    check_eq("t6_drop_count", 32'(drop_count), 32'(0));
    check_eq("t6_overflow", 32'(overflow), 32'(0));
    check_eq("t6_tlast", 32'(m_tlast), 32'(0));
    m_tready = 1'b1;
    step(1'b1, 32'h63);
    check_eq("t6_idle_valid", 32'(m_tvalid), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
